// File: rtl/response_misr_checker.sv
// rtl/response_misr_checker.sv - MISR response compactor with golden-signature compare.
// Optional X/Z detection on accepted samples: define RESPONSE_XCHECK_EN.
module response_misr_checker #(
  parameter int               WIDTH     = 481,
  parameter int               SIG_W     = 32,
  parameter int               VEC_COUNT = 21,
  parameter logic [SIG_W-1:0] POLY      = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED      = 32'hFFFFFFFF,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] sample_count,
  output logic             x_seen
);

  localparam int              NCH  = (WIDTH + SIG_W - 1) / SIG_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_n;
  logic [SIG_W-1:0]     sig_n, fold, misr_next;
  logic [CNT_W-1:0]     cnt_n;
  logic [NCH*SIG_W-1:0] y_ext;
  logic                 load, accept;

  always_comb begin
    y_ext = '0;
    y_ext[WIDTH-1:0] = y;
    fold = '0;
    for (int c = 0; c < NCH; c++) begin
      fold = fold ^ y_ext[c*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ fold;

  // Once the count reaches VEC_COUNT, RUN spends one more cycle without sampling before DONE.
  assign load   = (state != RUN) && start;
  assign accept = (state == RUN) && y_valid && (sample_count != LAST);

  always_comb begin
    state_n = state;
    sig_n   = signature;
    cnt_n   = sample_count;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (load) begin
          state_n = RUN;
          sig_n   = SEED;
          cnt_n   = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (sample_count == LAST) begin
          state_n = DONE;
        end else if (accept) begin
          sig_n = misr_next;
          cnt_n = sample_count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    pass = done && (signature == golden) && !x_seen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      signature    <= SEED;
      sample_count <= '0;
    end else begin
      state        <= state_n;
      signature    <= sig_n;
      sample_count <= cnt_n;
    end
  end

`ifdef RESPONSE_XCHECK_EN
  logic x_reg, x_reg_n;

  always_comb begin
    x_reg_n = x_reg;
    if (load) begin
      x_reg_n = 1'b0;
    end else if (accept && ((^y) === 1'bx)) begin
      x_reg_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= 1'b0;
    end else begin
      x_reg <= x_reg_n;
    end
  end

  assign x_seen = x_reg;
`else
  assign x_seen = 1'b0;
`endif

endmodule

// File: tb/tb_response_misr_checker.sv
// tb/tb_response_misr_checker.sv - randomized self-checking bench for response_misr_checker.
module tb_response_misr_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst, start, y_valid;
  logic [480:0] y;
  logic [31:0]  golden;

  logic        a_busy, a_done, a_pass, a_x;
  logic [31:0] a_sig;
  logic [15:0] a_cnt;
  logic        b_busy, b_done, b_pass, b_x;
  logic [31:0] b_sig;
  logic [15:0] b_cnt;
  logic        c_busy, c_done, c_pass, c_x;
  logic [31:0] c_sig;
  logic [15:0] c_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  response_misr_checker #(.VEC_COUNT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .y_valid(y_valid), .y(y), .golden(golden),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .sample_count(a_cnt), .x_seen(a_x));

  response_misr_checker #(.VEC_COUNT(1), .SEED(32'h0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .y_valid(y_valid), .y(y), .golden(golden),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .sample_count(b_cnt), .x_seen(b_x));

  response_misr_checker dut_c (
    .clk(clk), .rst(rst), .start(start), .y_valid(y_valid), .y(y), .golden(golden),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig), .sample_count(c_cnt), .x_seen(c_x));

  // Reference: bit i of the response lands on signature bit (i mod 32); the register
  // multiplies by x modulo the CRC-32 polynomial before adding the folded word.
  function automatic logic [31:0] ref_fold(input logic [480:0] v);
    logic [31:0] r = '0;
    for (int i = 0; i < 481; i++) r[i % 32] = r[i % 32] ^ v[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [480:0] v);
    logic [32:0] t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY};
    return t[31:0] ^ ref_fold(v);
  endfunction

  function automatic logic [480:0] rand_y();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom();
    return t[480:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; y_valid = 1'b0; y = '0; golden = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", c_busy); end
    checks++; if (c_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", c_done); end
    checks++; if (c_pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", c_pass); end
    checks++; if (c_sig !== SEED) begin errors++; $display("FAIL reset_sig got=%h exp=%h", c_sig, SEED); end
    checks++; if (c_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", c_cnt); end
    checks++; if (c_x !== 1'b0) begin errors++; $display("FAIL reset_xseen got=%b exp=0", c_x); end
    for (int i = 0; i < 3; i++) begin
      y = rand_y(); y_valid = 1'b1;
      @(negedge clk);
    end
    y_valid = 1'b0;
    checks++; if (c_sig !== SEED) begin errors++; $display("FAIL idle_sig got=%h exp=%h", c_sig, SEED); end
    checks++; if (c_cnt !== 16'd0) begin errors++; $display("FAIL idle_cnt got=%0d exp=0", c_cnt); end
  endtask

  task automatic test_single_zero();
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; y = '0; y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    checks++; if (a_sig !== 32'hFB3EE249) begin errors++; $display("FAIL zero_sig got=%h exp=FB3EE249", a_sig); end
    checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL zero_cnt got=%0d exp=1", a_cnt); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL zero_done_early got=%b exp=0", a_done); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", a_done); end
    golden = 32'hFB3EE249; #1;
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL zero_pass_match got=%b exp=1", a_pass); end
    golden = 32'hFB3EE248; #1;
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL zero_pass_miss got=%b exp=0", a_pass); end
  endtask

  task automatic test_folding();
    logic [480:0] pats [3];
    logic [31:0]  exps [3];
    pats[0] = '1;                      exps[0] = 32'hFFFFFFFE;
    pats[1] = '0; pats[1][480] = 1'b1; exps[1] = 32'h00000001;
    pats[2] = '0; pats[2][0] = 1'b1;   exps[2] = 32'h00000001;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; y = pats[p]; y_valid = 1'b1;
      @(negedge clk);
      y_valid = 1'b0;
      checks++; if (b_sig !== exps[p]) begin errors++; $display("FAIL fold_%0d got=%h exp=%h", p, b_sig, exps[p]); end
      checks++; if (b_sig !== ref_step(32'h0, pats[p])) begin errors++; $display("FAIL fold_model_%0d got=%h exp=%h", p, b_sig, ref_step(32'h0, pats[p])); end
    end
  endtask

  task automatic test_gaps();
    logic [31:0] m;
    int n;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = SEED; n = 0;
    for (int cyc = 0; cyc < 200 && n < 21; cyc++) begin
      checks++; if (c_busy !== 1'b1 || c_done !== 1'b0) begin errors++; $display("FAIL gap_busy cyc=%0d got busy=%b done=%b exp busy=1 done=0", cyc, c_busy, c_done); end
      checks++; if (c_cnt !== 16'(n)) begin errors++; $display("FAIL gap_cnt cyc=%0d got=%0d exp=%0d", cyc, c_cnt, n); end
      y = rand_y(); y_valid = (cyc % 2 == 0);
      if (y_valid) begin m = ref_step(m, y); n++; end
      @(negedge clk);
    end
    checks++; if (n != 21) begin errors++; $display("FAIL gap_budget got=%0d exp=21", n); end
    y = rand_y(); y_valid = 1'b1;
    checks++; if (c_cnt !== 16'd21 || c_done !== 1'b0 || c_busy !== 1'b1) begin errors++; $display("FAIL gap_final got cnt=%0d done=%b busy=%b exp cnt=21 done=0 busy=1", c_cnt, c_done, c_busy); end
    checks++; if (c_sig !== m) begin errors++; $display("FAIL gap_sig got=%h exp=%h", c_sig, m); end
    @(negedge clk);
    y_valid = 1'b0;
    checks++; if (c_done !== 1'b1 || c_busy !== 1'b0) begin errors++; $display("FAIL gap_done got done=%b busy=%b exp done=1 busy=0", c_done, c_busy); end
    checks++; if (c_sig !== m || c_cnt !== 16'd21) begin errors++; $display("FAIL gap_frozen got sig=%h cnt=%0d exp sig=%h cnt=21", c_sig, c_cnt, m); end
    golden = m; #1;
    checks++; if (c_pass !== 1'b1) begin errors++; $display("FAIL gap_pass got=%b exp=1", c_pass); end
    @(negedge clk);
    checks++; if (c_done !== 1'b1 || c_sig !== m) begin errors++; $display("FAIL gap_hold got done=%b sig=%h exp done=1 sig=%h", c_done, c_sig, m); end
  endtask

  task automatic test_reset_mid_run();
    logic [480:0] r;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      y = rand_y(); y_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (c_cnt !== 16'd10) begin errors++; $display("FAIL mid_cnt got=%0d exp=10", c_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; y_valid = 1'b0;
    checks++; if (c_busy !== 1'b0 || c_done !== 1'b0) begin errors++; $display("FAIL mid_state got busy=%b done=%b exp 0 0", c_busy, c_done); end
    checks++; if (c_cnt !== 16'd0 || c_sig !== SEED) begin errors++; $display("FAIL mid_regs got cnt=%0d sig=%h exp cnt=0 sig=%h", c_cnt, c_sig, SEED); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; y = rand_y(); y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL restart_pre_done got=%b exp=1", a_done); end
    start = 1'b1; y = rand_y(); y_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; r = rand_y(); y = r; y_valid = 1'b1;
    checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL restart_state got busy=%b done=%b exp 1 0", a_busy, a_done); end
    checks++; if (a_cnt !== 16'd0 || a_sig !== SEED) begin errors++; $display("FAIL restart_regs got cnt=%0d sig=%h exp cnt=0 sig=%h", a_cnt, a_sig, SEED); end
    @(negedge clk);
    y_valid = 1'b0;
    checks++; if (a_cnt !== 16'd1 || a_sig !== ref_step(SEED, r)) begin errors++; $display("FAIL restart_sample got cnt=%0d sig=%h exp cnt=1 sig=%h", a_cnt, a_sig, ref_step(SEED, r)); end
  endtask

  task automatic test_xcheck();
    logic [480:0] r;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; r = rand_y(); y = r;
`ifdef RESPONSE_XCHECK_EN
    r[7] = 1'b0; y[7] = 1'bx;
`endif
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    @(negedge clk);
    golden = ref_step(SEED, r); #1;
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL x_done got=%b exp=1", a_done); end
`ifdef RESPONSE_XCHECK_EN
    checks++; if (a_x !== 1'b1) begin errors++; $display("FAIL x_seen got=%b exp=1", a_x); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL x_pass got=%b exp=0", a_pass); end
`else
    checks++; if (a_x !== 1'b0) begin errors++; $display("FAIL x_seen got=%b exp=0", a_x); end
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL x_pass got=%b exp=1", a_pass); end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y_valid = 1'b0; y = '0; golden = '0;
    test_reset();
    test_single_zero();
    test_folding();
    test_gaps();
    test_reset_mid_run();
    test_xcheck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
